victim_way_select: RTL
======================

# victim_way_select

Picks the way to fill or evict on a cache miss in a set-associative cache, given the set index, the set's invalid-way mask and a lock mask. It prefers an unlocked invalid way, chosen lowest-first or highest-first. Otherwise it evicts round-robin from a per-set pointer, skipping locked ways. It sits between the miss handler and the tag/data array write port, and returns a registered result one cycle after each accepted request, under a valid/ready handshake.

## Interface
- LOG_WAYS, 2, log2 of associativity; WAYS = 2**LOG_WAYS.
- LOG_SETS, 6, log2 of set count; SETS = 2**LOG_SETS.
- PICK_HIGH, 0, invalid-way preference: 0 = lowest index first, 1 = highest index first.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_set  in  LOG_SETS  set index.
- req_invalid  in  WAYS  bit i = way i holds no valid line.
- req_lock  in  WAYS  bit i = way i must not be chosen.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes the result.
- resp_way  out  LOG_WAYS  chosen way.
- resp_fill  out  1  chosen way was invalid (no writeback needed).
- resp_none  out  1  no way is selectable; resp_way is 0.

## Operation
- Storage: rr_ptr[SETS], each LOG_WAYS bits wide; one output register holding resp_way, resp_fill and resp_none.
- Candidates: cand_inv = req_invalid & ~req_lock; cand_ev = ~req_lock.
- If cand_inv is nonzero:
  - resp_way = lowest set bit of cand_inv when PICK_HIGH = 0, highest set bit when PICK_HIGH = 1.
  - resp_fill = 1. rr_ptr[req_set] is unchanged.
- Else, if cand_ev is nonzero:
  - resp_way = first set bit of cand_ev, searching upward from rr_ptr[req_set] with wrap at WAYS.
  - resp_fill = 0.
  - rr_ptr[req_set] becomes (resp_way + 1) mod WAYS, computed in LOG_WAYS bits with natural wrap.
- Else: resp_none = 1, resp_way = 0, resp_fill = 0, and the pointer is unchanged.
- The pointer update and the output register load happen on the same edge as acceptance (req_valid & req_ready).
  - A back-to-back request to the same set therefore sees the updated pointer.
- There is no per-set state other than rr_ptr. Bits 0 of req_invalid/req_lock correspond to way 0.

## Timing
- Reset: resp_valid = 0, resp_way = 0, resp_fill = 0, resp_none = 0, and every rr_ptr = 0, all one cycle after reset is sampled high.
  - req_ready is held 0 while reset is high.
  - Reset asserted mid-transaction drops any pending result; it is not delivered.
- req_ready = ~resp_valid | resp_ready, combinational, so a full-throughput stream delivers one result per cycle.
- Latency: a request accepted at edge N has resp_valid high after edge N, valid in cycle N+1.
- resp_valid, once high, holds with stable resp_* until resp_ready is sampled high.
- Simultaneous accept and consume on one edge: the new result replaces the old one and resp_valid stays 1.
- Inputs are sampled only on accept and need not be held afterwards.

## Structure
- cache_pkg holds the shared constants and typedefs:
  - LOG_WAYS and LOG_SETS defaults;
  - way_t and set_t;
  - a victim_resp_t struct {way, fill, none} used by the miss handler.
- The search uses one sub-module, prio_find, instantiated twice.
  - Parameters: LOG_INPUTS and PICK_HIGH; an optional rotate start input.
  - Outputs: index and found.
  - Instance 1 does the fixed-priority invalid pick.
  - Instance 2 does the rotated eviction search: rotate right by ptr, find lowest, add ptr mod WAYS.
- rr_ptr is a register array cleared in the synchronous reset loop; no memory macro.

## Test plan
All scenarios use WAYS = 4 and SETS = 64.
- PICK_HIGH = 0, set 5, invalid = 4'b1010, lock = 0 -> next cycle: way 1, fill = 1, none = 0; rr_ptr[5] stays 0.
- PICK_HIGH = 1, same request -> way 3, fill = 1.
- Set 7, invalid = 0, lock = 0, four consecutive accepted requests -> ways 0, 1, 2, 3; a fifth request -> way 0 (pointer wrap).
- Set 7 with rr_ptr = 2, lock = 4'b0110, invalid = 0 -> way 3, pointer 0; next request -> way 0, pointer 1.
- lock = 4'b1111 with any invalid mask -> none = 1, way 0, fill = 0; pointer unchanged.
- Back-pressure: resp_ready held 0 for 3 cycles after a result -> req_ready = 0, resp_* stable. Reset pulsed during the stall -> resp_valid = 0 next cycle and all pointers read 0 afterwards.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults and victim-select payload types.
//   DEF_LOG_WAYS / DEF_LOG_SETS : default associativity / set-count exponents
//   way_t, set_t, way_mask_t    : index and mask types at default geometry
//   victim_resp_t               : {way, fill, none} result as seen by the miss handler
package cache_pkg;

   localparam int unsigned DEF_LOG_WAYS = 2;
   localparam int unsigned DEF_LOG_SETS = 6;
   localparam int unsigned DEF_WAYS     = 1 << DEF_LOG_WAYS;
   localparam int unsigned DEF_SETS     = 1 << DEF_LOG_SETS;

   typedef logic [DEF_LOG_WAYS-1:0] way_t;
   typedef logic [DEF_LOG_SETS-1:0] set_t;
   typedef logic [DEF_WAYS-1:0]     way_mask_t;

   typedef struct packed {
      way_t way;
      logic fill;
      logic none;
   } victim_resp_t;

   // Pack the three result fields the way the miss handler consumes them.
   function automatic victim_resp_t make_resp(way_t way, logic fill, logic none);
      victim_resp_t r;
      r.way  = way;
      r.fill = fill;
      r.none = none;
      return r;
   endfunction

endpackage

// File: rtl/victim_way_select_if.sv
// victim_way_select_if: request/response channel between miss handler and victim selector.
//   req_valid/req_ready     : request handshake
//   req_set/req_invalid/req_lock : set index, invalid-way mask, locked-way mask
//   resp_valid/resp_ready   : response handshake
//   resp_way/resp_fill/resp_none : chosen way, way was invalid, nothing selectable
//   master = miss handler side, slave = victim selector side
interface victim_way_select_if #(
   parameter int unsigned LOG_WAYS = cache_pkg::DEF_LOG_WAYS,
   parameter int unsigned LOG_SETS = cache_pkg::DEF_LOG_SETS
);

   localparam int unsigned WAYS = 1 << LOG_WAYS;

   logic                req_valid;
   logic                req_ready;
   logic [LOG_SETS-1:0] req_set;
   logic [WAYS-1:0]     req_invalid;
   logic [WAYS-1:0]     req_lock;
   logic                resp_valid;
   logic                resp_ready;
   logic [LOG_WAYS-1:0] resp_way;
   logic                resp_fill;
   logic                resp_none;

   modport master (
      output req_valid, req_set, req_invalid, req_lock, resp_ready,
      input  req_ready, resp_valid, resp_way, resp_fill, resp_none
   );

   modport slave (
      input  req_valid, req_set, req_invalid, req_lock, resp_ready,
      output req_ready, resp_valid, resp_way, resp_fill, resp_none
   );

endinterface

// File: rtl/prio_find.sv
// prio_find: priority search over a bit vector with an optional rotated start.
//   vec   : candidate bits, bit i = entry i
//   start : search origin; the vector is rotated right by start before the search
//   index : (found position in rotated vector + start) mod 2**LOG_INPUTS
//   found : any bit of vec set
// PICK_HIGH selects the highest set bit instead of the lowest (used with start = 0).
module prio_find #(
   parameter int unsigned LOG_INPUTS = 2,
   parameter bit          PICK_HIGH  = 1'b0
) (
   input  logic [(1<<LOG_INPUTS)-1:0] vec,
   input  logic [LOG_INPUTS-1:0]      start,
   output logic [LOG_INPUTS-1:0]      index,
   output logic                       found
);

   localparam int unsigned N = 1 << LOG_INPUTS;

   logic [2*N-1:0]        dbl;
   logic [N-1:0]          rot;
   logic [LOG_INPUTS-1:0] pos;

   // Rotate right by start: the low half of the doubled vector shifted down.
   always_comb begin
      dbl = {vec, vec} >> start;
      rot = dbl[N-1:0];
   end

   // Fixed-priority pick; the last match in loop order wins.
   always_comb begin
      pos = '0;
      if (PICK_HIGH) begin
         for (int i = 0; i < int'(N); i++) begin
            if (rot[i]) pos = LOG_INPUTS'(i);
         end
      end else begin
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (rot[i]) pos = LOG_INPUTS'(i);
         end
      end
   end

   // Undo the rotation; natural wrap in LOG_INPUTS bits.
   assign index = pos + start;
   assign found = |vec;

endmodule

// File: rtl/victim_way_select.sv
// victim_way_select: picks the way to fill or evict on a cache miss.
//   clk, reset : clock, synchronous active-high reset
//   bus        : victim_way_select_if.slave
//                request  {set, invalid mask, lock mask} under req_valid/req_ready
//                response {way, fill, none} under resp_valid/resp_ready, one cycle after accept
// Unlocked invalid ways are preferred (lowest or highest index per PICK_HIGH);
// otherwise a per-set round-robin pointer chooses the next unlocked way.
module victim_way_select
   import cache_pkg::*;
#(
   parameter int unsigned LOG_WAYS  = DEF_LOG_WAYS,
   parameter int unsigned LOG_SETS  = DEF_LOG_SETS,
   parameter bit          PICK_HIGH = 1'b0
) (
   input logic                clk,
   input logic                reset,
   victim_way_select_if.slave bus
);

   localparam int unsigned WAYS = 1 << LOG_WAYS;
   localparam int unsigned SETS = 1 << LOG_SETS;

   logic [LOG_WAYS-1:0] rr_ptr [SETS];

   logic [LOG_WAYS-1:0] ptr_cur;
   logic [WAYS-1:0]     cand_inv;
   logic [WAYS-1:0]     cand_ev;
   logic [LOG_WAYS-1:0] inv_idx;
   logic [LOG_WAYS-1:0] ev_idx;
   logic                inv_found;
   logic                ev_found;

   logic                ready;
   logic                accept;

   logic [LOG_WAYS-1:0] nxt_way;
   logic                nxt_fill;
   logic                nxt_none;
   logic                ptr_we;

   logic                resp_valid_q;
   logic [LOG_WAYS-1:0] resp_way_q;
   logic                resp_fill_q;
   logic                resp_none_q;

   // Handshake: a slot is free when empty or being drained; closed during reset.
   assign ready  = ~reset & (~resp_valid_q | bus.resp_ready);
   assign accept = bus.req_valid & ready;

   // Candidate masks.
   always_comb begin
      ptr_cur  = rr_ptr[bus.req_set];
      cand_inv = bus.req_invalid & ~bus.req_lock;
      cand_ev  = ~bus.req_lock;
   end

   // Invalid-way pick: fixed priority, no rotation.
   prio_find #(
      .LOG_INPUTS (LOG_WAYS),
      .PICK_HIGH  (PICK_HIGH)
   ) u_inv_find (
      .vec   (cand_inv),
      .start ('0),
      .index (inv_idx),
      .found (inv_found)
   );

   // Eviction pick: lowest unlocked way at or after the set's pointer, wrapping.
   prio_find #(
      .LOG_INPUTS (LOG_WAYS),
      .PICK_HIGH  (1'b0)
   ) u_ev_find (
      .vec   (cand_ev),
      .start (ptr_cur),
      .index (ev_idx),
      .found (ev_found)
   );

   // Result selection and pointer-advance decision.
   always_comb begin
      nxt_way  = '0;
      nxt_fill = 1'b0;
      nxt_none = 1'b0;
      ptr_we   = 1'b0;
      if (inv_found) begin
         nxt_way  = inv_idx;
         nxt_fill = 1'b1;
      end else if (ev_found) begin
         nxt_way  = ev_idx;
         ptr_we   = 1'b1;
      end else begin
         nxt_none = 1'b1;
      end
   end

   // Output register and round-robin pointers; a new result may replace one being consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         resp_way_q   <= '0;
         resp_fill_q  <= 1'b0;
         resp_none_q  <= 1'b0;
         for (int s = 0; s < int'(SETS); s++) begin
            rr_ptr[s] <= '0;
         end
      end else begin
         if (accept) begin
            resp_valid_q <= 1'b1;
            resp_way_q   <= nxt_way;
            resp_fill_q  <= nxt_fill;
            resp_none_q  <= nxt_none;
            if (ptr_we) begin
               rr_ptr[bus.req_set] <= ev_idx + LOG_WAYS'(1);
            end
         end else if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_way   = resp_way_q;
   assign bus.resp_fill  = resp_fill_q;
   assign bus.resp_none  = resp_none_q;

endmodule
